// File: rtl/clk_prescaler_pkg.sv
// Shared definitions for the prescaler controller: default widths and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package clk_prescaler_pkg;

   // Divisor width matches the prescaler ROM word; 16-entry ROM by default.
   localparam int DIV_W_DEF = 24;
   localparam int IDX_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_RUN   = 2'd2,
      ST_SWAP  = 2'd3
   } state_t;

endpackage

// File: rtl/clk_prescaler_cnt.sv
// Loadable down-counter with terminal-count flag for the prescaler.
// Latency: load/decrement take effect at the next rising edge; o_tc is combinational from the count.
// Backpressure: none; i_en low freezes the count, i_load overrides counting.
// Ports: i_clk/i_rst clock and sync reset, i_en count enable, i_load/i_load_val forced load,
//        i_reload_val value taken when the count wraps at zero, o_tc high while count is zero.
module clk_prescaler_cnt
   import clk_prescaler_pkg::*;
#(
   parameter int W = DIV_W_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic [W-1:0] i_reload_val,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   assign o_tc = (r_cnt == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en) begin
         // Wrap at zero back to the divisor: N+1 enabled cycles per period.
         r_cnt <= o_tc ? i_reload_val : (r_cnt - W'(1));
      end
   end

endmodule

// File: rtl/clk_prescaler_ctrl.sv
// Prescaler controller: glitch-free divisor change from a combinational ROM, tick clock-enable output.
// Latency: sel_ack one cycle after accept; new divisor takes effect at the next terminal count after FETCH.
// Backpressure: sel_req is held by the requester until sel_ack; requests are ignored while busy.
// Ports: clk/rst clock and sync active-high reset, run count enable, sel_req/sel_idx/sel_ack request
//        handshake, busy change in progress, rom_ad/rom_dout ROM lookup, tick period pulse,
//        cur_idx index of the divisor in force.
module clk_prescaler_ctrl
   import clk_prescaler_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             sel_req,
   input  logic [IDX_W-1:0] sel_idx,
   output logic             sel_ack,
   output logic             busy,
   output logic [IDX_W-1:0] rom_ad,
   input  logic [DIV_W-1:0] rom_dout,
   output logic             tick,
   output logic [IDX_W-1:0] cur_idx
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_valid;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_pend_div;
   logic [IDX_W-1:0] r_pend_idx;
   logic [IDX_W-1:0] r_cur_idx;
   logic             r_tick;
   logic             r_ack;

   logic             w_tc;
   logic             w_cnt_en;
   logic             w_term;
   logic             w_accept;
   logic             w_init_load;
   logic             w_latch_pend;
   logic             w_swap;
   logic             w_cnt_load;
   logic [DIV_W-1:0] w_cnt_load_val;

   // Counting runs off the divisor in force regardless of FSM state, so
   // FETCH/SWAP never stretch or cut the current period.
   assign w_cnt_en = r_valid & run;
   assign w_term   = w_cnt_en & w_tc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_init_load  = 1'b0;
      w_latch_pend = 1'b0;
      w_swap       = 1'b0;
      busy         = 1'b0;
      rom_ad       = r_cur_idx;
      case (r_state)
         ST_IDLE, ST_RUN: begin
            if (sel_req) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            busy   = 1'b1;
            rom_ad = r_pend_idx;
            // First divisor ever loads straight in; later ones wait for a terminal count.
            if (!r_valid) begin
               w_init_load = 1'b1;
               w_state_nxt = ST_RUN;
            end else begin
               w_latch_pend = 1'b1;
               w_state_nxt  = ST_SWAP;
            end
         end
         ST_SWAP: begin
            busy = 1'b1;
            if (w_term) begin
               w_swap      = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // A swap replaces the wrap-around reload with the pending divisor, so the
   // period that just ended was entirely old and the next is entirely new.
   assign w_cnt_load     = w_init_load | w_swap;
   assign w_cnt_load_val = w_init_load ? rom_dout : r_pend_div;

   clk_prescaler_cnt #(
      .W(DIV_W)
   ) u_cnt (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (w_cnt_en),
      .i_load       (w_cnt_load),
      .i_load_val   (w_cnt_load_val),
      .i_reload_val (r_div),
      .o_tc         (w_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_div      <= '0;
         r_pend_div <= '0;
         r_pend_idx <= '0;
         r_cur_idx  <= '0;
         r_tick     <= 1'b0;
         r_ack      <= 1'b0;
      end else begin
         r_tick <= w_term;
         r_ack  <= w_accept;
         if (w_accept) begin
            r_pend_idx <= sel_idx;
         end
         if (w_init_load) begin
            r_div     <= rom_dout;
            r_cur_idx <= r_pend_idx;
            r_valid   <= 1'b1;
         end
         if (w_latch_pend) begin
            r_pend_div <= rom_dout;
         end
         if (w_swap) begin
            r_div     <= r_pend_div;
            r_cur_idx <= r_pend_idx;
         end
      end
   end

   assign sel_ack = r_ack;
   assign tick    = r_tick;
   assign cur_idx = r_cur_idx;

endmodule

// File: doc/clk_prescaler_ctrl.md
CLK_PRESCALER_CTRL -- requirements
Module: clk_prescaler_ctrl

Interface
REQ-001 Parameter DIV_W, default 24, SHALL set the divisor and counter width (matches the prescaler ROM word).
REQ-002 Parameter IDX_W, default 4, SHALL set the prescaler ROM index width (16 entries).
REQ-003 Port clk, input, 1: single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port run, input, 1: count enable; counter holds while low.
REQ-006 Port sel_req, input, 1: request to apply prescaler setting sel_idx; held high until sel_ack is seen.
REQ-007 Port sel_idx, input, IDX_W: requested ROM index, valid while sel_req is high.
REQ-008 Port sel_ack, output, 1: one-cycle acceptance pulse.
REQ-009 Port busy, output, 1: high while a change is in progress (states FETCH and SWAP).
REQ-010 Port rom_ad, output, IDX_W: address to the combinational prescaler ROM.
REQ-011 Port rom_dout, input, DIV_W: ROM data for rom_ad, same cycle.
REQ-012 Port tick, output, 1: registered one-cycle clock-enable pulse.
REQ-013 Port cur_idx, output, IDX_W: index of the divisor currently in force.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, RUN and SWAP; reset state is IDLE.
REQ-015 Accept: in IDLE or RUN, sel_req=1 SHALL capture pend_idx<=sel_idx, enter FETCH and pulse sel_ack in the following cycle; sel_req is ignored in FETCH and SWAP and never acked there.
REQ-016 A sel_req still high in the cycle after the sel_ack pulse SHALL count as a new request.
REQ-017 rom_ad SHALL equal pend_idx in FETCH and cur_idx in all other states.
REQ-018 FETCH with no valid divisor (entered from IDLE) SHALL load div<=rom_dout, cnt<=rom_dout, cur_idx<=pend_idx, set valid, and go to RUN.
REQ-019 FETCH with a valid divisor (entered from RUN) SHALL latch pend_div<=rom_dout and go to SWAP.
REQ-020 Counting: when valid and run=1, cnt SHALL decrement each cycle; at cnt==0 it SHALL reload with div, and tick SHALL be 1 in the next cycle.
REQ-021 Tick period SHALL be N+1 cycles of run=1 for ROM value N; N=0 SHALL give tick every cycle.
REQ-022 Counting SHALL continue uninterrupted with the old divisor during FETCH and SWAP.
REQ-023 SWAP: at the first cnt==0 with run=1, the controller SHALL tick, load div<=pend_div, cnt<=pend_div and cur_idx<=pend_idx, then go to RUN.
REQ-024 A terminal count coinciding with FETCH SHALL reload the old divisor; the swap SHALL wait for the next terminal count.
REQ-025 run=0 SHALL freeze cnt and suppress tick in every state; FSM transitions and handshake SHALL still proceed.
REQ-026 Requesting the index already in force SHALL run the full FETCH/SWAP sequence with no period glitch.
REQ-027 No tick period SHALL ever be shorter than min(old,new)+1 or mix partial counts across a swap.

Reset
REQ-028 rst SHALL force IDLE, valid=0, cnt=0, div=0, pend_div=0, pend_idx=0, cur_idx=0, tick=0, sel_ack=0, busy=0, rom_ad=0.
REQ-029 rst asserted mid-FETCH or mid-SWAP SHALL abandon the pending change with no ack and no tick.

Structure
REQ-030 Package clk_prescaler_pkg SHALL hold DIV_W/IDX_W defaults and the FSM state enum.
REQ-031 The loadable down-counter with terminal-count flag SHALL be sub-module clk_prescaler_cnt; the FSM and handshake stay in the top module.

Verification (ROM model: idx2=1, idx3=4, idx4=8, idx13=0x14996F)
REQ-032 Reset, run=1, req idx3 -> ack one cycle later, cur_idx=3, tick every 5 cycles.
REQ-033 Running idx3, req idx4 -> ack, busy high until next terminal count, last old period 5, then periods of 9, cur_idx=4.
REQ-034 Req idx0 (N=0) -> tick high every cycle; run low 3 cycles -> tick low, cnt held, resumes cleanly.
REQ-035 sel_req held high through FETCH/SWAP with changing sel_idx -> exactly one ack; captured index is the one from the accept cycle.
REQ-036 Rst pulse during SWAP -> all outputs at reset values next cycle; no tick until a new request completes.
REQ-037 Random requests/run toggling vs. reference period model -> every tick interval equals the ROM value in force +1.
